// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver that decodes shadowed hex data one digit per scan slot.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam bit LOW   = (SEG_ACTIVE_LOW != 0);

  localparam logic [6:0]            SEG_OFF = LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [CNT_W-1:0]        div_cnt;
  logic                    cnt_wrap;
  logic [IDX_W-1:0]        next_idx;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              nibble;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   an_hot;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  assign cnt_wrap = (div_cnt == CNT_W'(SCAN_DIV - 1));
  assign next_idx = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // A digit is blank only if it and every more-significant nibble are zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    blank      = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (shadow_val[4*i +: 4] == 4'h0);
      blank[i]   = upper_zero;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    nibble   = shadow_val[4*digit_idx +: 4];
    seg_raw  = blank[digit_idx] ? 7'h00 : hex_to_seg(nibble);
    an_hot   = NUM_DIGITS'(1) << digit_idx;
    seg_next = LOW ? ~seg_raw : seg_raw;
    dp_next  = LOW ? ~shadow_dp[digit_idx] : shadow_dp[digit_idx];
    an_next  = LOW ? ~an_hot : an_hot;
  end

  // an, seg and dp are all registered from the same digit_idx, so they switch together.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      div_cnt    <= '0;
      digit_idx  <= '0;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (cnt_wrap) begin
        div_cnt   <= '0;
        digit_idx <= next_idx;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      seg <= seg_next;
      dp  <= dp_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a 4-digit active-low instance and a
// 1-digit active-high instance, both compared every cycle against a timing model.
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic [2:0] idx;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0]  seg1;
  logic        dp1;
  logic [3:0]  an1;
  logic [1:0]  idx1;
  logic [6:0]  seg2;
  logic        dp2;
  logic [0:0]  an2;
  logic [0:0]  idx2;

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int pops   = 0;

  out_t q1[$];
  out_t q2[$];

  int          m_k   = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp  = '0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg1), .dp(dp1), .an(an1), .digit_idx(idx1)
  );

  seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(1), .SEG_ACTIVE_LOW(0)) dut_single (
    .clk(clk), .rst(rst), .load(load), .value(value[3:0]), .dp_in(dp_in[0:0]),
    .seg(seg2), .dp(dp2), .an(an2), .digit_idx(idx2)
  );

  always #5 clk = ~clk;

  // Expected pins after edge k (k-th edge since reset release). The digit shown is
  // the one selected before that edge; digit_idx reports the one selected after it.
  function automatic out_t model(input int n, input int div, input int low, input int k,
                                 input logic [31:0] val, input logic [7:0] dpv,
                                 input bit in_reset);
    out_t       o;
    int         shown;
    logic [3:0] nib;
    logic [6:0] raw;
    logic [7:0] hot;
    logic [7:0] mask;
    mask = 8'((1 << n) - 1);
    if (in_reset) begin
      o.seg = (low != 0) ? 7'h7F : 7'h00;
      o.dp  = (low != 0);
      o.an  = (low != 0) ? mask : 8'h00;
      o.idx = '0;
      return o;
    end
    shown = ((k - 1) / div) % n;
    nib   = 4'(val >> (4 * shown));
    raw   = hex_tab[nib];
`ifdef LEADING_ZERO_BLANK_EN
    if (shown > 0 && (val >> (4 * shown)) == 0) raw = 7'h00;
`endif
    hot   = 8'(1 << shown);
    o.seg = (low != 0) ? ~raw : raw;
    o.dp  = (low != 0) ? ~dpv[shown] : dpv[shown];
    o.an  = (low != 0) ? (~hot & mask) : hot;
    o.idx = 3'((k / div) % n);
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue what both DUTs must show after the coming edge.
  task automatic step(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    rst   = r;
    load  = l;
    value = v;
    dp_in = d;
    if (r) begin
      m_k   = 0;
      m_val = '0;
      m_dp  = '0;
      q1.push_back(model(4, 4, 1, 0, 32'h0, 8'h0, 1'b1));
      q2.push_back(model(1, 1, 0, 0, 32'h0, 8'h0, 1'b1));
    end else begin
      m_k++;
      q1.push_back(model(4, 4, 1, m_k, {16'h0, m_val}, {4'h0, m_dp}, 1'b0));
      q2.push_back(model(1, 1, 0, m_k, {28'h0, m_val[3:0]}, {7'h0, m_dp[0]}, 1'b0));
      if (l) begin
        m_val = v;
        m_dp  = d;
      end
    end
    pushes++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  // Monitor: the pins are valid every cycle, so one expectation is consumed per edge.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("quad_seg", seg1, e.seg);
        check("quad_dp",  dp1,  e.dp);
        check("quad_an",  an1,  e.an);
        check("quad_idx", idx1, e.idx);
        pops++;
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("single_seg", seg2, e.seg);
        check("single_dp",  dp2,  e.dp);
        check("single_an",  an2,  e.an);
        check("single_idx", idx2, e.idx);
      end
    end
  end

  initial begin
    logic [15:0] v;
    int          guard;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(2);

    step(1'b0, 1'b1, 16'h1234, 4'h0);
    idle(36);

    // Reload in the middle of the digit 1 slot; an timing must not move.
    guard = 0;
    while (!(((m_k / 4) % 4) == 1 && (m_k % 4) == 1) && guard < 64) begin
      idle(1);
      guard++;
    end
    check("align_digit1_slot", guard < 64, 1);
    step(1'b0, 1'b1, 16'hABCD, 4'b0010);
    idle(20);

    // Reset wins over a simultaneous load.
    step(1'b1, 1'b1, 16'hFFFF, 4'hF);
    idle(18);

    step(1'b0, 1'b1, 16'h0042, 4'b0100);
    idle(18);
    step(1'b0, 1'b1, 16'h0000, 4'h0);
    idle(18);
    step(1'b0, 1'b1, 16'h0008, 4'h1);
    step(1'b0, 1'b1, 16'h9005, 4'h8);
    idle(18);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        step(1'b1, $urandom_range(0, 1) == 1, $urandom, $urandom);
      end else begin
        v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        step(1'b0, $urandom_range(0, 3) == 0, v, 4'($urandom));
      end
    end

    @(negedge clk);
    load  = 1'b0;
    guard = 0;
    while ((q1.size() > 0 || q2.size() > 0) && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("drain_quad_queue", q1.size(), 0);
    check("drain_single_queue", q2.size(), 0);
    check("expectations_consumed", pops, pushes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
